regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2^ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rd1_addr, rd2_addr  input  ADDR_W  read port addresses.
REQ-007 rd1_data, rd2_data  output  DATA_W  read port data, combinational.
REQ-008 rd1_busy, rd2_busy  output  1  addressed register has a pending write.
REQ-009 wr_en  input  1  write strobe.
REQ-010 wr_addr  input  ADDR_W  write address; wr_data  input  DATA_W  write data.
REQ-011 iss_en  input  1  issue strobe: marks iss_addr as pending destination.
REQ-012 iss_addr  input  ADDR_W  destination register being issued.
REQ-013 clr_req  input  1  one-cycle request to zero the whole file.
REQ-014 ready  output  1  high in IDLE; low while clearing.

Function
REQ-015 Write: in IDLE, when wr_en=1, the register at wr_addr SHALL take wr_data at the next rising clk edge.
REQ-016 Read: rdN_data SHALL be the current contents of rdN_addr, with no clock latency.
REQ-017 Bypass: if wr_en=1, wr_addr=rdN_addr and the address is writable, rdN_data SHALL equal wr_data in the same cycle.
REQ-018 ZERO_REG=1: address 0 SHALL read 0, bypass to it SHALL be suppressed, and writes and issues to it SHALL be ignored.
REQ-019 Scoreboard: one busy bit per register. iss_en sets busy[iss_addr] at the next edge; wr_en clears busy[wr_addr] at the next edge.
REQ-020 Simultaneous iss_en and wr_en to the same address: set SHALL win, and busy stays 1.
REQ-021 rdN_busy = busy[rdN_addr] AND NOT (wr_en AND wr_addr=rdN_addr); this lets the bypassed value be consumed without a stall.
REQ-022 FSM states: IDLE and CLEAR.
REQ-023 IDLE -> CLEAR when clr_req=1; CLEAR -> IDLE after the edge that writes index DEPTH-1.
REQ-024 CLEAR: an index counter starts at 0 and writes 0 to one register per cycle, incrementing each cycle. The sweep takes exactly DEPTH cycles.
REQ-025 On the edge entering CLEAR, all busy bits SHALL clear.
REQ-026 During CLEAR, wr_en, iss_en and clr_req SHALL be ignored. rdN_data and rdN_busy SHALL read 0. ready SHALL be 0.
REQ-027 Same-cycle clr_req with wr_en/iss_en in IDLE: the clear takes priority, and the write or issue is dropped.
REQ-028 Counter SHALL be ADDR_W bits wide, with no wrap beyond DEPTH-1.

Reset
REQ-029 While rst_n=0: all registers = 0, all busy bits = 0, state = IDLE, counter = 0, ready = 1, rdN_busy = 0.
REQ-030 rst_n asserted mid-CLEAR SHALL abort the sweep immediately. After rst_n deasserts, the block SHALL be in IDLE with every register 0.
REQ-031 Reset deassertion SHALL take effect at the first rising edge after rst_n goes high.

Verification
REQ-032 Reset, then read addresses 0, 5, 31 -> data 0, busy 0, ready 1.
REQ-033 Write 0xDEADBEEF to r8. Next cycle read r8 on both ports -> 0xDEADBEEF. Write 0x1 to r0, then read r0 -> 0.
REQ-034 Same cycle wr_en r9=0x1234 with rd1_addr=9 -> rd1_data=0x1234 in that cycle, and rd1_busy=0.
REQ-035 Issue r10, then read r10 -> busy 1. Write r10 while also issuing r10 -> busy stays 1. Write r10 alone -> busy 0 next cycle.
REQ-036 Fill r1..r31 with non-zero values, then pulse clr_req -> ready low for exactly 32 cycles, then all reads are 0 and all busy bits are 0. A wr_en during the sweep has no effect.
REQ-037 Assert rst_n low at sweep cycle 10, release, then read r20 (value written pre-sweep) -> 0, ready 1, state IDLE.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file bundle: two read ports with busy flags, write port, issue port, clear request.
// master: drives addresses, write/issue/clear strobes and samples data, busy and ready.
// slave:  the register file itself.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] rd2_addr;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              rd1_busy;
    logic              rd2_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              clr_req;
    logic              ready;

    modport master (
        output rd1_addr, rd2_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        input  rd1_data, rd2_data, rd1_busy, rd2_busy, ready
    );

    modport slave (
        input  rd1_addr, rd2_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        output rd1_data, rd2_data, rd1_busy, rd2_busy, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Purpose: 2-read/1-write register file with per-register pending-write scoreboard and a sweep clear.
// Latency: reads are combinational with same-cycle write bypass; writes/issues land on the next edge.
// Backpressure: ready drops for exactly DEPTH cycles during a clear; inputs are ignored meanwhile.
// Ports: clk, rst_n (async active-low), bus (regfile_mp_if.slave): rd1/rd2 addr->data+busy,
//        wr_en/wr_addr/wr_data, iss_en/iss_addr, clr_req, ready.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;

    logic idle;
    logic wr_ok;
    logic iss_ok;
    logic wr_fire;
    logic iss_fire;
    logic clr_start;
    logic cnt_last;

    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              rd1_busy;
    logic              rd2_busy;
    logic              ready;

    // Register 0 is hardwired when ZERO_REG is set: no writes, issues or bypass to it.
    assign wr_ok     = (ZERO_REG == 0) || (bus.wr_addr != '0);
    assign iss_ok    = (ZERO_REG == 0) || (bus.iss_addr != '0);
    assign idle      = (state_q == IDLE);
    // A clear request in the same cycle wins: the write/issue is dropped.
    assign wr_fire   = idle && bus.wr_en  && !bus.clr_req && wr_ok;
    assign iss_fire  = idle && bus.iss_en && !bus.clr_req && iss_ok;
    assign clr_start = idle && bus.clr_req;
    assign cnt_last  = (cnt_q == {ADDR_W{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ready
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sweep index: starts at 0 on entry, leaves CLEAR after writing DEPTH-1, parks back at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard: clear on write, then set on issue so a same-address issue wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (clr_start) begin
            busy_q <= '0;
        end else begin
            if (wr_fire) begin
                busy_q[bus.wr_addr] <= 1'b0;
            end
            if (iss_fire) begin
                busy_q[bus.iss_addr] <= 1'b1;
            end
        end
    end

    // Read port 1: forced to 0 while clearing; bypass masks busy so the consumer need not stall.
    always_comb begin
        rd1_data = '0;
        rd1_busy = 1'b0;
        if (idle) begin
            if (wr_fire && (bus.wr_addr == bus.rd1_addr)) begin
                rd1_data = bus.wr_data;
            end else if ((ZERO_REG == 0) || (bus.rd1_addr != '0)) begin
                rd1_data = mem[bus.rd1_addr];
            end
            rd1_busy = busy_q[bus.rd1_addr] && !(wr_fire && (bus.wr_addr == bus.rd1_addr));
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        rd2_data = '0;
        rd2_busy = 1'b0;
        if (idle) begin
            if (wr_fire && (bus.wr_addr == bus.rd2_addr)) begin
                rd2_data = bus.wr_data;
            end else if ((ZERO_REG == 0) || (bus.rd2_addr != '0)) begin
                rd2_data = mem[bus.rd2_addr];
            end
            rd2_busy = busy_q[bus.rd2_addr] && !(wr_fire && (bus.wr_addr == bus.rd2_addr));
        end
    end

    assign bus.rd1_data = rd1_data;
    assign bus.rd2_data = rd2_data;
    assign bus.rd1_busy = rd1_busy;
    assign bus.rd2_busy = rd2_busy;
    assign bus.ready    = ready;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, write/read, zero register, bypass, scoreboard,
// full clear sweep with ignored inputs, and reset in the middle of a sweep.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        bus.rd1_addr = a1;
        bus.rd2_addr = a2;
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int n;
        quiet();
        bus.rd1_addr = '0;
        bus.rd2_addr = '0;

        // Values while reset is held
        #3;
        rd(5'd5, 5'd31);
        check("rst_hold_ready", bus.ready, 1);
        check("rst_hold_busy1", bus.rd1_busy, 0);
        check("rst_hold_data1", bus.rd1_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset state on addresses 0, 5, 31
        rd(5'd0, 5'd5);
        check("rst_r0_data", bus.rd1_data, 0);
        check("rst_r5_data", bus.rd2_data, 0);
        check("rst_r0_busy", bus.rd1_busy, 0);
        rd(5'd31, 5'd31);
        check("rst_r31_data", bus.rd1_data, 0);
        check("rst_r31_busy", bus.rd2_busy, 0);
        check("rst_ready", bus.ready, 1);

        // Plain write then read on both ports
        wr(5'd8, 32'hDEADBEEF);
        rd(5'd8, 5'd8);
        check("r8_port1", bus.rd1_data, 32'hDEADBEEF);
        check("r8_port2", bus.rd2_data, 32'hDEADBEEF);

        // Zero register: no bypass, no write
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1;
        rd(5'd0, 5'd8);
        check("r0_no_bypass", bus.rd1_data, 0);
        tick();
        bus.wr_en = 1'b0;
        rd(5'd0, 5'd0);
        check("r0_after_write", bus.rd1_data, 0);

        // Same-cycle bypass
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h1234;
        rd(5'd9, 5'd8);
        check("bypass_r9_data", bus.rd1_data, 32'h1234);
        check("bypass_r9_busy", bus.rd1_busy, 0);
        check("bypass_other_port", bus.rd2_data, 32'hDEADBEEF);
        tick();
        bus.wr_en = 1'b0;
        rd(5'd9, 5'd9);
        check("r9_stored", bus.rd2_data, 32'h1234);

        // Scoreboard
        bus.iss_en = 1'b1; bus.iss_addr = 5'd10;
        tick();
        bus.iss_en = 1'b0;
        rd(5'd10, 5'd10);
        check("r10_issued_busy", bus.rd1_busy, 1);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd10;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h55;
        tick();
        quiet();
        rd(5'd10, 5'd10);
        check("r10_set_wins", bus.rd2_busy, 1);
        check("r10_data_written", bus.rd1_data, 32'h55);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h66;
        rd(5'd10, 5'd10);
        check("r10_busy_masked", bus.rd1_busy, 0);
        tick();
        bus.wr_en = 1'b0;
        rd(5'd10, 5'd10);
        check("r10_busy_cleared", bus.rd1_busy, 0);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        tick();
        bus.iss_en = 1'b0;
        rd(5'd0, 5'd0);
        check("r0_issue_ignored", bus.rd1_busy, 0);

        // Fill r1..r31, mark r12 busy, then clear (same-cycle write to r5 dropped)
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h1000 + i);
        end
        bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
        tick();
        bus.iss_en = 1'b0;
        rd(5'd20, 5'd12);
        check("fill_r20", bus.rd1_data, 32'h1014);
        check("pre_clr_r12_busy", bus.rd2_busy, 1);
        bus.clr_req = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hBAD;
        tick();
        quiet();
        n = 0;
        while (bus.ready == 1'b0 && n < 100) begin
            n++;
            if (n == 20) begin
                bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hBAD3;
                bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
                rd(5'd3, 5'd31);
                check("sweep_rd_zero", bus.rd1_data, 0);
                check("sweep_busy_zero", bus.rd1_busy, 0);
            end
            tick();
            quiet();
        end
        check("clr_ready_low_cycles", n, 32);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check($sformatf("clr_data_r%0d", i), bus.rd1_data, 0);
            check($sformatf("clr_busy_r%0d", i), bus.rd1_busy, 0);
        end

        // Reset in the middle of a sweep
        wr(5'd20, 32'hABCD);
        rd(5'd20, 5'd20);
        check("pre_abort_r20", bus.rd1_data, 32'hABCD);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (10) tick();
        check("mid_sweep_ready", bus.ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_ready_in_reset", bus.ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd(5'd20, 5'd20);
        check("abort_r20", bus.rd1_data, 0);
        check("abort_ready", bus.ready, 1);
        wr(5'd7, 32'h77);
        rd(5'd7, 5'd7);
        check("abort_idle_write", bus.rd1_data, 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
